fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised operand-forwarding and interlock unit, issued from the ID stage. It tracks every in-flight register write in a DEPTH-slot shift register that mirrors the back end of the pipeline, so callers no longer supply per-stage rd/RegWrite. For each of NSRC source operands it outputs a forwarding select, and it raises a stall when the youngest matching producer's result is not yet available. Unlike the fixed two-source EX/MEM and MEM/WB forwarder, it supports any depth, any source count, per-instruction result latency, pipeline-wide hold and a saturating stall counter.

## Interface
- NSRC, 2, number of source operands checked per instruction
- RAW, 5, register address width
- DEPTH, 3, tracked stages after ID; slot 1 = instruction issued last cycle
- SELW, $clog2(DEPTH+1), width of one select field
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  NSRC*RAW  source i at [i*RAW +: RAW]
- id_rs_used  in  NSRC  source i is actually read
- id_rd  in  RAW  destination register
- id_we  in  1  instruction writes id_rd
- id_rdy  in  SELW  first slot (1..DEPTH) at which the result is forwardable: ALU = 1, load = 2
- flush  in  1  squash the instruction in ID this cycle
- mem_hold  in  1  whole pipeline frozen this cycle
- fwd_sel  out  NSRC*SELW  per source: 0 = register file, k = forward from slot k
- stall  out  1  ID must hold; a bubble enters slot 1
- stall_cnt  out  32  saturating count of stall cycles

## Operation
- Slot state, per slot k in 1..DEPTH: valid, rd, rdy.
  - Only entries with we=1 and rd≠0 are ever inserted, so valid implies a real write.
- Match for source i:
  - Requires id_valid, id_rs_used[i], id_rs[i]≠0, slot valid and slot rd = id_rs[i].
  - The smallest k (youngest) wins. Older matching slots are ignored, even if the youngest is not ready.
- Per source i, with k the youngest match:
  - No match: fwd_sel[i] = 0.
  - k ≥ rdy(k): fwd_sel[i] = k.
  - k < rdy(k): fwd_sel[i] = 0, and source i requests a stall.
- stall = OR of the per-source requests. It is combinational from slot state and ID inputs.
- stall is forced to 0 when flush=1, because a flushed instruction never issues.
- Update rule, on every clk edge with rst_n=1 and mem_hold=0:
  - Slot k+1 <= slot k for k = 1..DEPTH-1. Slot DEPTH retires; its register-file write lands at this same edge.
  - Slot 1 <= {1, id_rd, id_rdy} if id_valid & id_we & id_rd≠0 & !stall & !flush. Otherwise slot 1 <= invalid (bubble).
- mem_hold=1: no slot changes.
  - fwd_sel and stall are still computed from the frozen state.
  - stall_cnt does not increment.
- stall_cnt:
  - Increments by 1 on each edge where stall=1 and mem_hold=0.
  - Saturates at 32'hFFFF_FFFF.
- id_rdy = 0 is treated as 1. id_rdy > DEPTH is treated as DEPTH.

## Timing
- Reset (rst_n=0 at an edge):
  - All slots invalid; stall_cnt = 0.
  - While rst_n=0, outputs are forced to fwd_sel = 0 and stall = 0.
  - Reset mid-operation discards all tracked producers. There is no retirement effect.
- fwd_sel and stall have zero latency from ID inputs, i.e. they are valid in the same cycle.
- A producer issued at edge n is in slot 1 during cycle n+1 and in slot k during cycle n+k. It leaves after cycle n+DEPTH.
- A load (rdy=2) followed immediately by a dependent instruction:
  - stall=1 for exactly 1 cycle.
  - On the next cycle the producer is in slot 2 and fwd_sel = 2.
- With rdy = r, an adjacent dependent instruction stalls r−1 cycles, plus any mem_hold cycles.
- Simultaneous stall and flush: flush wins. There is no stall, no insert, and stall_cnt is unchanged.
- Producer in slot DEPTH at the same edge the consumer reads:
  - The consumer sees the forward (sel = DEPTH) in that cycle.
  - In the next cycle it sees the register file (sel = 0).

## Test plan
- ALU chain: issue rd=5 (rdy=1); next cycle ID reads rs0=5 → fwd_sel[0]=1, stall=0; cycle after, rs1=5 → fwd_sel[1]=2.
- Load-use: issue rd=7 (rdy=2); next cycle rs1=7 → stall=1 for 1 cycle, stall_cnt=1; then fwd_sel[1]=2, stall=0.
- Youngest-wins: rd=3 with rdy=1 is in slot 2 and rd=3 with rdy=2 is in slot 1; rs0=3 → stall=1 (no fallback to slot 2); next cycle fwd_sel[0]=2.
- Zero/unused: rd=0 producer, or id_rs_used[0]=0 with a matching rs0 → fwd_sel[0]=0, stall=0.
- Hold and flush:
  - Pending load-use with mem_hold=1 for 3 cycles → stall stays 1, slots frozen, stall_cnt unchanged; the release cycle stalls once.
  - flush in a stall cycle → stall=0, slot 1 bubble.
- Reset mid-run: slots 1..3 valid, drive rst_n=0 for 1 edge → fwd_sel=0, stall=0, stall_cnt=0. After release, the same rs produce sel=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding / load-use interlock tracking DEPTH in-flight writes issued from ID.
// Latency: fwd_sel_o/stall_o are combinational from slot state and ID inputs; slots advance each edge.
// Backpressure: stall_o holds ID and inserts a bubble; mem_hold_i freezes every slot and the stall counter.
module fwd_hazard_unit #(
  parameter int NSRC  = 2,
  parameter int RAW   = 5,
  parameter int DEPTH = 3,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 id_valid_i,
  input  logic [NSRC*RAW-1:0]  id_rs_i,
  input  logic [NSRC-1:0]      id_rs_used_i,
  input  logic [RAW-1:0]       id_rd_i,
  input  logic                 id_we_i,
  input  logic [SELW-1:0]      id_rdy_i,
  input  logic                 flush_i,
  input  logic                 mem_hold_i,
  output logic [NSRC*SELW-1:0] fwd_sel_o,
  output logic                 stall_o,
  output logic [31:0]          stall_cnt_o
);

  // Index 0 holds slot 1 (issued last cycle); index DEPTH-1 holds the retiring slot.
  logic [DEPTH-1:0] slot_vld_q;
  logic [RAW-1:0]   slot_rd_q  [DEPTH];
  logic [SELW-1:0]  slot_rdy_q [DEPTH];
  logic [31:0]      stall_cnt_q;

  logic [NSRC-1:0]      src_hit;
  logic [SELW-1:0]      src_k   [NSRC];
  logic [SELW-1:0]      src_rdy [NSRC];
  logic [NSRC-1:0]      stall_req;
  logic [NSRC*SELW-1:0] fwd_sel_c;
  logic                 stall_raw;
  logic [SELW-1:0]      rdy_norm;
  logic                 slot1_vld_d;
  logic [31:0]          stall_cnt_d;

  // Clamp the producer's ready slot into 1..DEPTH before it is stored.
  always_comb begin
    rdy_norm = id_rdy_i;
    if (id_rdy_i == '0) begin
      rdy_norm = SELW'(1);
    end else if (id_rdy_i > SELW'(DEPTH)) begin
      rdy_norm = SELW'(DEPTH);
    end
  end

  // Per source: find the youngest matching slot, then forward from it or request a stall.
  always_comb begin
    stall_req = '0;
    fwd_sel_c = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_hit[i] = 1'b0;
      src_k[i]   = '0;
      src_rdy[i] = '0;
      // Scan oldest to youngest so the youngest match overwrites any older one.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (id_valid_i && id_rs_used_i[i] && (id_rs_i[i*RAW +: RAW] != '0) &&
            slot_vld_q[k] && (slot_rd_q[k] == id_rs_i[i*RAW +: RAW])) begin
          src_hit[i] = 1'b1;
          src_k[i]   = SELW'(k + 1);
          src_rdy[i] = slot_rdy_q[k];
        end
      end
      if (src_hit[i]) begin
        if (src_k[i] >= src_rdy[i]) begin
          fwd_sel_c[i*SELW +: SELW] = src_k[i];
        end else begin
          stall_req[i] = 1'b1;
        end
      end
    end
  end

  // A flushed instruction never issues, so it can never be the one that stalls.
  assign stall_raw   = (|stall_req) && !flush_i;
  assign slot1_vld_d = id_valid_i && id_we_i && (id_rd_i != '0) && !stall_raw && !flush_i;
  assign stall_cnt_d = (stall_raw && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                     : stall_cnt_q;

  assign fwd_sel_o   = rst_n_i ? fwd_sel_c : '0;
  assign stall_o     = rst_n_i && stall_raw;
  assign stall_cnt_o = stall_cnt_q;

  // Advance the producer shift register and stall counter unless the pipeline is held.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      slot_vld_q  <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd_q[k]  <= '0;
        slot_rdy_q[k] <= '0;
      end
    end else if (!mem_hold_i) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slot_vld_q[k] <= slot_vld_q[k-1];
        slot_rd_q[k]  <= slot_rd_q[k-1];
        slot_rdy_q[k] <= slot_rdy_q[k-1];
      end
      slot_vld_q[0] <= slot1_vld_d;
      slot_rd_q[0]  <= id_rd_i;
      slot_rdy_q[0] <= rdy_norm;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then random traffic against a producer-list model.
module tb_fwd_hazard_unit;
  localparam int NSRC  = 2;
  localparam int RAW   = 5;
  localparam int DEPTH = 3;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 id_valid;
  logic [NSRC*RAW-1:0]  id_rs;
  logic [NSRC-1:0]      id_rs_used;
  logic [RAW-1:0]       id_rd;
  logic                 id_we;
  logic [SELW-1:0]      id_rdy;
  logic                 flush;
  logic                 mem_hold;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall;
  logic [31:0]          stall_cnt;

  fwd_hazard_unit #(.NSRC(NSRC), .RAW(RAW), .DEPTH(DEPTH), .SELW(SELW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs),
    .id_rs_used_i(id_rs_used), .id_rd_i(id_rd), .id_we_i(id_we), .id_rdy_i(id_rdy),
    .flush_i(flush), .mem_hold_i(mem_hold), .fwd_sel_o(fwd_sel), .stall_o(stall),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: list of issued producers, each stamped with the advance count at issue.
  // Its slot number is simply how many advancing edges have passed since then.
  typedef struct { int rd; int rdy; int t; } prod_t;
  prod_t q[$];
  int    tick;
  bit [31:0] m_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [NSRC*SELW-1:0] obs_sel;
  logic                 obs_stall;
  logic [31:0]          obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_eval(output logic [NSRC*SELW-1:0] sel, output logic stl);
    logic req;
    sel = '0;
    req = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      int rs;
      int best;
      int brdy;
      rs   = int'(id_rs[i*RAW +: RAW]);
      best = 0;
      brdy = 0;
      foreach (q[j]) begin
        int s;
        s = tick - q[j].t;
        if (s >= 1 && s <= DEPTH && q[j].rd == rs && (best == 0 || s < best)) begin
          best = s;
          brdy = q[j].rdy;
        end
      end
      if (id_valid && id_rs_used[i] && rs != 0 && best != 0) begin
        if (best >= brdy) sel[i*SELW +: SELW] = SELW'(best);
        else req = 1'b1;
      end
    end
    stl = req && !flush;
    if (!rst_n) begin
      sel = '0;
      stl = 1'b0;
    end
  endfunction

  // One cycle: drive inputs, check mid-cycle against the model, then apply the edge to the model.
  task automatic step(input logic v, input int rs0, input int rs1, input logic [1:0] used,
                      input int rd, input logic we, input int rdy,
                      input logic fl, input logic hd, input logic rn);
    logic [NSRC*SELW-1:0] esel;
    logic                 estl;
    int                   r;
    id_valid   = v;
    id_rs      = {RAW'(rs1), RAW'(rs0)};
    id_rs_used = used;
    id_rd      = RAW'(rd);
    id_we      = we;
    id_rdy     = SELW'(rdy);
    flush      = fl;
    mem_hold   = hd;
    rst_n      = rn;
    @(negedge clk);
    model_eval(esel, estl);
    obs_sel   = fwd_sel;
    obs_stall = stall;
    obs_cnt   = stall_cnt;
    chk("fwd_sel", 32'(obs_sel), 32'(esel));
    chk("stall", 32'(obs_stall), 32'(estl));
    chk("stall_cnt", obs_cnt, m_cnt);
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_cnt = 0;
    end else if (!hd) begin
      if (estl && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (v && we && rd != 0 && !estl && !fl) begin
        r = (rdy == 0) ? 1 : (rdy > DEPTH ? DEPTH : rdy);
        q.push_back('{rd: rd, rdy: r, t: tick});
      end
      tick++;
      while (q.size() > 0 && tick - q[0].t > DEPTH) void'(q.pop_front());
    end
    #1;
  endtask

  task automatic iss(input int rd, input int rdy);
    step(1'b1, 0, 0, 2'b00, rd, 1'b1, rdy, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd2(input int rs0, input int rs1, input logic [1:0] used, input logic hd);
    step(1'b1, rs0, rs1, used, 0, 1'b0, 1, 1'b0, hd, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 2'b00, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
  endtask

  logic [31:0] c0;

  initial begin
    tick = 0;
    m_cnt = 0;
    rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_we = 1'b0; id_rdy = '0; flush = 1'b0; mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    step(1'b0, 0, 0, 2'b00, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset_cnt", obs_cnt, 32'd0);

    // ALU chain
    iss(5, 1);
    rd2(5, 0, 2'b01, 1'b0);
    chk("alu_sel1", 32'(obs_sel), 32'h1);
    chk("alu_nostall", 32'(obs_stall), 32'h0);
    rd2(0, 5, 2'b10, 1'b0);
    chk("alu_sel2", 32'(obs_sel), 32'h8);

    // Load-use
    iss(7, 2);
    rd2(0, 7, 2'b10, 1'b0);
    chk("lu_stall", 32'(obs_stall), 32'h1);
    c0 = obs_cnt;
    rd2(0, 7, 2'b10, 1'b0);
    chk("lu_fwd", 32'(obs_sel), 32'h8);
    chk("lu_release", 32'(obs_stall), 32'h0);
    chk("lu_cnt", obs_cnt, c0 + 32'd1);

    // Youngest match wins even when it is not ready yet
    iss(3, 1);
    iss(3, 2);
    rd2(3, 0, 2'b01, 1'b0);
    chk("young_stall", 32'(obs_stall), 32'h1);
    rd2(3, 0, 2'b01, 1'b0);
    chk("young_sel", 32'(obs_sel), 32'h2);

    // Zero destination and unused source
    iss(0, 1);
    rd2(0, 0, 2'b01, 1'b0);
    chk("rd0_sel", 32'(obs_sel), 32'h0);
    iss(9, 1);
    rd2(9, 9, 2'b00, 1'b0);
    chk("unused_sel", 32'(obs_sel), 32'h0);
    chk("unused_stall", 32'(obs_stall), 32'h0);

    // Held load-use: stall persists, counter frozen, release cycle stalls once
    iss(7, 2);
    c0 = stall_cnt;
    repeat (3) begin
      rd2(0, 7, 2'b10, 1'b1);
      chk("hold_stall", 32'(obs_stall), 32'h1);
      chk("hold_cnt", obs_cnt, c0);
    end
    rd2(0, 7, 2'b10, 1'b0);
    chk("hold_rel_stall", 32'(obs_stall), 32'h1);
    rd2(0, 7, 2'b10, 1'b0);
    chk("hold_rel_sel", 32'(obs_sel), 32'h8);
    chk("hold_rel_cnt", obs_cnt, c0 + 32'd1);

    // Flush in a stall cycle
    iss(6, 2);
    c0 = stall_cnt;
    step(1'b1, 6, 0, 2'b01, 8, 1'b1, 1, 1'b1, 1'b0, 1'b1);
    chk("flush_stall", 32'(obs_stall), 32'h0);
    rd2(6, 8, 2'b11, 1'b0);
    chk("flush_bubble", 32'(obs_sel), 32'h2);
    chk("flush_cnt", obs_cnt, c0);

    // Producer in the last slot, then retired
    iss(14, 1);
    idle();
    idle();
    rd2(14, 0, 2'b01, 1'b0);
    chk("last_slot", 32'(obs_sel), 32'h3);
    rd2(14, 0, 2'b01, 1'b0);
    chk("retired", 32'(obs_sel), 32'h0);

    // rdy=0 behaves as rdy=1; rdy=DEPTH stalls DEPTH-1 cycles
    iss(15, 0);
    rd2(0, 15, 2'b10, 1'b0);
    chk("rdy0_sel", 32'(obs_sel), 32'h4);
    iss(16, 3);
    rd2(16, 0, 2'b01, 1'b0);
    chk("rdy3_st1", 32'(obs_stall), 32'h1);
    rd2(16, 0, 2'b01, 1'b0);
    chk("rdy3_st2", 32'(obs_stall), 32'h1);
    rd2(16, 0, 2'b01, 1'b0);
    chk("rdy3_sel", 32'(obs_sel), 32'h3);

    // Reset mid-run
    iss(10, 1);
    iss(11, 1);
    iss(12, 1);
    step(1'b1, 12, 11, 2'b11, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    chk("rst_sel", 32'(obs_sel), 32'h0);
    chk("rst_stall", 32'(obs_stall), 32'h0);
    rd2(12, 11, 2'b11, 1'b0);
    chk("post_rst_sel", 32'(obs_sel), 32'h0);
    chk("post_rst_cnt", obs_cnt, 32'd0);

    // Random traffic on a small register range to force frequent hazards
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(9, 0) != 0,
           int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
           2'($urandom_range(3, 0)),
           int'($urandom_range(7, 0)), $urandom_range(3, 0) != 0,
           int'($urandom_range(3, 0)),
           $urandom_range(9, 0) == 0, $urandom_range(6, 0) == 0,
           $urandom_range(59, 0) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
